// File: rtl/wb2core_pkg.sv
// Shared types and sizing helpers for the Wishbone-to-core slave bridge.
package wb2core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/wb2core_outstanding_ctr.sv
// Counts granted-but-unanswered core requests; saturates at MAX and never wraps below zero.
module wb2core_outstanding_ctr
    import wb2core_pkg::*;
#(
    parameter int MAX = 2,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt_nxt,
    output logic         full,
    output logic         zero
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         inc_ok;
    logic         dec_ok;

    assign full    = (cnt_q == MAX_C);
    assign zero    = (cnt_q == '0);
    assign cnt_nxt = cnt_d;

    // A decrement at zero is a stray response and is dropped here.
    always_comb begin
        inc_ok = inc & ~full;
        dec_ok = dec & ~zero;
        cnt_d  = cnt_q;
        if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb2core.sv
// Wishbone B4 pipelined slave that issues req/gnt/rvalid core requests and returns
// in-order responses as registered ack/err; drains responses when the master drops cyc.
//
// state | meaning
// IDLE  | nothing outstanding
// BUSY  | requests outstanding, cycle still open
// DRAIN | cycle dropped with requests outstanding; responses discarded, bus stalled
module wb2core
    import wb2core_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_adr,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel,
    output logic            wb_stall,
    output logic            wb_ack,
    output logic            wb_err,
    output logic [DW-1:0]   wb_dat_o,
    output logic            core_req,
    input  logic            core_gnt,
    output logic            core_we,
    output logic [DW/8-1:0] core_be,
    output logic [AW-1:0]   core_addr,
    output logic [DW-1:0]   core_wdata,
    input  logic            core_rvalid,
    input  logic [DW-1:0]   core_rdata,
    input  logic            core_err
);

    localparam int CW = cnt_w(MAX_OUTSTANDING);

    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [CW-1:0] cnt_nxt;
    logic          full;
    logic          zero;
    logic          accept;
    logic          resp_ok;

    wb2core_outstanding_ctr #(
        .MAX (MAX_OUTSTANDING),
        .W   (CW)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (accept),
        .dec     (core_rvalid),
        .cnt_nxt (cnt_nxt),
        .full    (full),
        .zero    (zero)
    );

    assign core_req   = wb_cyc & wb_stb & ~full & (state_q != DRAIN);
    assign wb_stall   = (state_q == DRAIN) | full | (core_req & ~core_gnt);
    assign accept     = core_req & core_gnt;
    assign core_we    = wb_we;
    assign core_be    = wb_sel;
    assign core_addr  = wb_adr;
    assign core_wdata = wb_dat_i;

    // Only forward responses that belong to a live cycle; strays at zero are dropped.
    assign resp_ok = core_rvalid & ~zero & wb_cyc & (state_q != DRAIN);

    always_comb begin
        ack_d   = resp_ok & ~core_err;
        err_d   = resp_ok & core_err;
        dat_d   = core_rvalid ? core_rdata : dat_q;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cnt_nxt != '0) state_d = BUSY;
            end
            BUSY: begin
                if (cnt_nxt == '0) state_d = IDLE;
                else if (!wb_cyc)  state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_nxt == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_err   = err_q;
    assign wb_dat_o = dat_q;

endmodule
